// File: rtl/deemph_pkg.sv
// deemph_pkg: shared types and constants for the deemph_iir de-emphasis filter
package deemph_pkg;
  typedef logic signed [11:0] sample_t;
  typedef logic signed [11:0] coef_t;
  typedef logic signed [23:0] prod_t;
  typedef logic signed [27:0] acc_t;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  localparam acc_t    ROUND_CONST = acc_t'(1 << 9);
  localparam sample_t SAT_MAX     = sample_t'(2047);
  localparam sample_t SAT_MIN     = sample_t'(-2048);
endpackage

// File: rtl/deemph_iir_if.sv
// deemph_iir_if: valid/ready sample streams in and out of deemph_iir
//   in_valid/in_ready/in_data    : input samples x[n], Q2.10
//   out_valid/out_ready/out_data : output samples y[n], Q2.10
//   master = sample source / sink side, slave = filter side
interface deemph_iir_if;
  import deemph_pkg::*;
  logic    in_valid;
  logic    in_ready;
  sample_t in_data;
  logic    out_valid;
  logic    out_ready;
  sample_t out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/deemph_round_sat.sv
// deemph_round_sat: round half-up Q8.20 accumulator to Q2.10 sample
//   acc : accumulator in, y : rounded sample out
//   DEEMPH_SAT_EN defined: clamp to [-2048, 2047]; otherwise bits [21:10] wrap
module deemph_round_sat
  import deemph_pkg::*;
(
  input  acc_t    acc,
  output sample_t y
);
`ifdef DEEMPH_SAT_EN
  logic signed [17:0] q;
  assign q = 18'((acc + ROUND_CONST) >>> 10);
  assign y = q > 18'(SAT_MAX) ? SAT_MAX : q < 18'(SAT_MIN) ? SAT_MIN : sample_t'(q);
`else
  assign y = sample_t'((acc + ROUND_CONST) >>> 10);
`endif
endmodule

// File: rtl/deemph_iir.sv
// deemph_iir: time-multiplexed second-order IIR de-emphasis, one shared multiplier
//   clk, rst_n (async active-low), clr (sync flush of history and in-flight sample)
//   s : deemph_iir_if.slave carrying the input and output valid/ready streams
//   B0..A2 : Q2.10 coefficients; y = B0*x + B1*x1 + B2*x2 - A1*y1 - A2*y2
//   Optional saturation via DEEMPH_SAT_EN (handled in deemph_round_sat)
module deemph_iir
  import deemph_pkg::*;
#(
  parameter coef_t B0 = 12'sd256,
  parameter coef_t B1 = 12'sd0,
  parameter coef_t B2 = 12'sd0,
  parameter coef_t A1 = -12'sd768,
  parameter coef_t A2 = 12'sd0
) (
  input logic        clk,
  input logic        rst_n,
  input logic        clr,
  deemph_iir_if.slave s
);
  state_t     state, state_nxt;
  logic [2:0] tap;
  acc_t       acc;
  sample_t    x, x1, x2, y1, y2, y, d;
  coef_t      c;
  prod_t      p;
  logic       accept, load;
  always_comb begin
    accept    = state == IDLE && s.in_valid && !clr;
    load      = state == DONE && (!s.out_valid || s.out_ready) && !clr;
    c         = tap == 3'd0 ? B0 : tap == 3'd1 ? B1 : tap == 3'd2 ? B2 : tap == 3'd3 ? A1 : A2;
    d         = tap == 3'd0 ? x : tap == 3'd1 ? x1 : tap == 3'd2 ? x2 : tap == 3'd3 ? y1 : y2;
    p         = prod_t'(c) * prod_t'(d);
    state_nxt = clr ? IDLE : accept ? MAC : (state == MAC && tap == 3'd4) ? DONE : load ? IDLE : state;
  end
  assign s.in_ready = rst_n && !clr && state == IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // Feedback taps (3, 4) subtract the product so -A never needs negating in 12 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap <= '0; acc <= '0; x <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
    end else if (clr) begin
      tap <= '0; acc <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
      s.out_valid <= 1'b0;
    end else begin
      if (accept) begin
        x   <= s.in_data;
        tap <= '0;
        acc <= '0;
      end
      if (state == MAC) begin
        acc <= tap < 3'd3 ? acc + acc_t'(p) : acc - acc_t'(p);
        tap <= tap + 3'd1;
      end
      if (load) begin
        s.out_data  <= y;
        s.out_valid <= 1'b1;
        x2 <= x1; x1 <= x; y2 <= y1; y1 <= y;
      end else if (s.out_valid && s.out_ready) s.out_valid <= 1'b0;
    end
  end
  deemph_round_sat u_rs (.acc(acc), .y(y));
endmodule

// File: doc/deemph_iir.md
# deemph_iir

- Time-multiplexed second-order IIR de-emphasis filter.
- Restores the spectrum of a stream shaped by the emphasis FIR stage, using one shared multiplier and a valid/ready handshake on both sides.
- Sits on the receive path, directly after the emphasis/channel stage. Samples are Q2.10, 12-bit signed.

## Interface
- B0, 256: feed-forward coefficient b0, Q2.10 signed 12-bit (0.25)
- B1, 0: coefficient b1, Q2.10
- B2, 0: coefficient b2, Q2.10
- A1, -768: feedback coefficient a1, Q2.10 (-0.75)
- A2, 0: feedback coefficient a2, Q2.10
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: clears history and aborts any sample in flight
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  12  input sample x[n], Q2.10
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_data  out  12  output y[n], Q2.10

## Operation
- Equation: y[n] = B0·x[n] + B1·x[n-1] + B2·x[n-2] − A1·y[n-1] − A2·y[n-2].
- History registers x1, x2, y1, y2 hold the rounded Q2.10 values.
- Each product is 12×12 → 24-bit signed, Q4.20.
- Accumulator is 28-bit signed, Q8.20. It cannot overflow.
- Round half-up: add 2^9, then take bits [21:10] as the Q2.10 result.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid, capture in_data → MAC with tap=0 and acc=0.
  - MAC: one product per cycle, in tap order 0..4 (B0·x, B1·x1, B2·x2, −A1·y1, −A2·y2). After tap 4 → DONE.
  - DONE: if the output register is free (!out_valid or out_ready), load out_data, set out_valid, shift history (x2←x1, x1←x, y2←y1, y1←y) → IDLE. Otherwise hold in DONE with no state change.
- out_valid drops on an out_valid&&out_ready cycle, unless a new result loads in that same cycle.
- History updates only when a result loads into out_data. A stalled result therefore never corrupts the recursion.
- clr (highest priority after reset), on the next edge:
  - x1, x2, y1, y2, acc ← 0; out_valid ← 0; state ← IDLE.
  - Any sample in flight is dropped.
  - An in_valid in the same cycle is not accepted; in_ready is 0 while clr=1.
- Reset values: out_valid=0, out_data=0, state IDLE, all history 0. in_ready=0 while rst_n is low.

## Timing
- Accept at edge E0. Taps accumulate on E1..E5. Result loads on E6 when downstream is free.
- out_valid is high from E6: 6-cycle latency.
- Throughput: one sample per 7 cycles with no backpressure. in_ready is high again the cycle after E6.
- Backpressure: the block stalls in DONE indefinitely. in_ready stays low, so no sample is ever lost.
- Input data must be stable only on the accept edge.
- rst_n asserted mid-operation: immediate return to reset values, independent of clk.

## Configuration
- DEEMPH_SAT_EN defined:
  - The rounded 28-bit result is clamped to [-2048, 2047] before loading out_data and y1.
- DEEMPH_SAT_EN undefined:
  - Bits [21:10] are taken directly (two's-complement wrap). There is no clamp logic.

## Structure
- deemph_pkg:
  - sample_t (signed 12), coef_t (signed 12), prod_t (signed 24), acc_t (signed 28).
  - state_t enum {IDLE, MAC, DONE}.
  - ROUND_CONST = 1<<9; SAT_MAX = 2047; SAT_MIN = -2048.
- Sub-module deemph_round_sat: combinational round plus optional saturate, acc_t → sample_t. This is the only place DEEMPH_SAT_EN is tested.

## Test plan
- Reset: rst_n low → out_valid=0, out_data=0, in_ready=0. Release → in_ready=1.
- Impulse, default params: x = 1024, then 0,0,0,0,0 → y = 256, 192, 144, 108, 81, 61. Each out_valid rises exactly 6 cycles after its accept.
- Backpressure: out_ready=0, send samples 1024 and 0.
  - Second is accepted, then the block stalls in DONE with in_ready=0 and out_data=256 held.
  - Raise out_ready → 256 then 192 delivered, nothing dropped.
- Saturation: B0=2047, A1=0, x=2047.
  - With DEEMPH_SAT_EN → out_data=2047.
  - Without → out_data=-4 (4092 wrapped).
- clr mid-MAC: assert clr on cycle E3 of a 1024 sample → no output is produced, and the history is cleared. Next x=1024 → y=256.
- Async reset mid-DONE stall → outputs return to reset values immediately. The next impulse reproduces 256, 192, ….
